// File: rtl/brlite_svc_rx_fifo_pkg.sv
// Shared types for the BrLite service-receive path: router flit, stored service
// entry, the service-type code and the receive handshake states.
package brlite_svc_rx_fifo_pkg;

  typedef struct packed {
    logic [1:0]  service;
    logic [15:0] seq_source;
    logic [15:0] seq_target;
    logic [15:0] producer;
    logic [7:0]  ksvc;
    logic [31:0] payload;
  } brlite_flit_t;

  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;

  localparam logic [1:0] BRLITE_SVC_SERVICE = 2'd1;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  // service and seq_target are consumed by the filter and never stored
  function automatic brlite_svc_t flit_to_svc(input brlite_flit_t flit);
    brlite_svc_t svc;
    svc.ksvc       = flit.ksvc;
    svc.seq_source = flit.seq_source;
    svc.producer   = flit.producer;
    svc.payload    = flit.payload;
    return svc;
  endfunction

endpackage

// File: rtl/dmni_sync_fifo.sv
// Synchronous first-word fall-through FIFO with a separate occupancy count so
// full and empty stay distinguishable when the wrapping pointers coincide.
module dmni_sync_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output T                         head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_en_s;
  logic               pop_en_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_en_s = push && !full;
  assign pop_en_s  = pop && !empty;
  assign count     = count_r;
  assign head      = mem[rd_ptr_r];

  // storage array write port
  always_ff @(posedge clk_i) begin
    if (push_en_s) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

  // pointer and occupancy bookkeeping; simultaneous push and pop leaves count alone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/brlite_svc_rx_fifo.sv
// BrLite service-receive front end: req/ack handshake with the router, service
// filter with saturating drop counter, and a FWFT buffer towards the NI.
module brlite_svc_rx_fifo
  import brlite_svc_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     br_req_i,
  output logic                     br_ack_o,
  input  brlite_flit_t             br_data_i,
  output logic                     br_svc_rx_o,
  output brlite_svc_t              br_svc_data_o,
  input  logic                     br_svc_ack_i,
  output logic [$clog2(DEPTH):0]   svc_count_o,
  output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

  rx_state_t               state_r;
  logic                    ack_r;
  logic [DROP_CNT_W-1:0]   drop_cnt_r;
  logic                    is_svc_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    accept_s;
  logic                    push_s;
  brlite_svc_t             head_s;
  logic [$clog2(DEPTH):0]  count_s;

  assign is_svc_s = (br_data_i.service == BRLITE_SVC_SERVICE);

  // Full is judged on this cycle's registered count, so a same-cycle pop never frees a slot
  always_comb begin
    accept_s = 1'b0;
    push_s   = 1'b0;
    if ((state_r == RX_IDLE) && br_req_i && (!is_svc_s || !fifo_full_s)) begin
      accept_s = 1'b1;
      push_s   = is_svc_s;
    end else begin
      accept_s = 1'b0;
      push_s   = 1'b0;
    end
  end

  // handshake FSM; req is ignored in ACK because the router still holds it there
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= RX_IDLE;
      ack_r      <= 1'b0;
      drop_cnt_r <= {DROP_CNT_W{1'b0}};
    end else begin
      case (state_r)
        RX_IDLE: begin
          if (accept_s) begin
            state_r <= RX_ACK;
            ack_r   <= 1'b1;
            if (!is_svc_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
              drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
            end
          end else begin
            state_r <= RX_IDLE;
            ack_r   <= 1'b0;
          end
        end
        RX_ACK: begin
          state_r <= RX_IDLE;
          ack_r   <= 1'b0;
        end
        default: begin
          state_r <= RX_IDLE;
          ack_r   <= 1'b0;
        end
      endcase
    end
  end

  dmni_sync_fifo #(
    .T     (brlite_svc_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push_s),
    .push_data (flit_to_svc(br_data_i)),
    .pop       (br_svc_ack_i),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (count_s),
    .head      (head_s)
  );

  assign br_ack_o      = ack_r;
  assign br_svc_rx_o   = !fifo_empty_s;
  assign br_svc_data_o = head_s;
  assign svc_count_o   = count_s;
  assign drop_cnt_o    = drop_cnt_r;

endmodule

// File: tb/tb_brlite_svc_rx_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based transaction model of the router handshake and service buffer.
module tb_brlite_svc_rx_fifo;
  import brlite_svc_rx_fifo_pkg::*;

  localparam int DEPTH    = 8;
  localparam int DROP_W   = 16;
  localparam int DROP_MAX = 65535;

  logic               clk_i;
  logic               rst_ni;
  logic               br_req_i;
  logic               br_ack_o;
  brlite_flit_t       br_data_i;
  logic               br_svc_rx_o;
  brlite_svc_t        br_svc_data_o;
  logic               br_svc_ack_i;
  logic [3:0]         svc_count_o;
  logic [DROP_W-1:0]  drop_cnt_o;

  brlite_svc_t mq[$];
  bit          m_ack;
  int          m_drops;
  bit          rt_seen;
  int          n_cmp;
  int          n_mis;

  brlite_svc_rx_fifo #(.DEPTH(DEPTH), .DROP_CNT_W(DROP_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .br_req_i      (br_req_i),
    .br_ack_o      (br_ack_o),
    .br_data_i     (br_data_i),
    .br_svc_rx_o   (br_svc_rx_o),
    .br_svc_data_o (br_svc_data_o),
    .br_svc_ack_i  (br_svc_ack_i),
    .svc_count_o   (svc_count_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic brlite_flit_t mk_flit(input logic [1:0] svc, input logic [7:0] ksvc,
                                           input logic [15:0] prod, input logic [15:0] src,
                                           input logic [31:0] pay);
    brlite_flit_t f;
    f.service    = svc;
    f.seq_source = src;
    f.seq_target = 16'($urandom);
    f.producer   = prod;
    f.ksvc       = ksvc;
    f.payload    = pay;
    return f;
  endfunction

  function automatic brlite_flit_t rnd_flit(input logic [1:0] svc);
    return mk_flit(svc, 8'($urandom), 16'($urandom), 16'($urandom), $urandom);
  endfunction

  function automatic brlite_svc_t expect_entry(input brlite_flit_t f);
    brlite_svc_t s;
    s = '{ksvc: f.ksvc, seq_source: f.seq_source, producer: f.producer, payload: f.payload};
    return s;
  endfunction

  // Transaction model: one accept per idle cycle, buffer capacity DEPTH, saturating drops
  task automatic model_edge();
    bit pop_ok;
    bit acc;
    int sz;
    sz     = mq.size();
    pop_ok = br_svc_ack_i && (sz != 0);
    acc    = !m_ack && br_req_i && ((br_data_i.service != 2'd1) || (sz < DEPTH));
    if (pop_ok) void'(mq.pop_front());
    if (acc) begin
      if (br_data_i.service == 2'd1) mq.push_back(expect_entry(br_data_i));
      else if (m_drops < DROP_MAX) m_drops++;
    end
    m_ack = acc;
  endtask

  task automatic check_all();
    check_eq("ack", 72'(br_ack_o), 72'(m_ack));
    check_eq("svc_rx", 72'(br_svc_rx_o), 72'(mq.size() != 0));
    check_eq("count", 72'(svc_count_o), 72'(mq.size()));
    check_eq("drop_cnt", 72'(drop_cnt_o), 72'(m_drops));
    if (mq.size() != 0) check_eq("head", br_svc_data_o, mq[0]);
  endtask

  // one clock: model at the edge, compare at the falling edge, then router/NI reactions
  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all();
    br_svc_ack_i = 1'b0;
    if (br_req_i && rt_seen) begin
      br_req_i = 1'b0;
      rt_seen  = 1'b0;
    end else if (br_req_i && br_ack_o) begin
      rt_seen = 1'b1;
    end
  endtask

  task automatic offer(input brlite_flit_t f);
    br_data_i = f;
    br_req_i  = 1'b1;
    rt_seen   = 1'b0;
  endtask

  task automatic send(input brlite_flit_t f, input int max_cycles);
    offer(f);
    for (int i = 0; i < max_cycles && br_req_i; i++) step();
    if (br_req_i) begin
      check_eq("send_done", 72'(br_req_i), 72'(0));
      br_req_i = 1'b0;
      rt_seen  = 1'b0;
    end
  endtask

  task automatic pop();
    br_svc_ack_i = 1'b1;
    step();
  endtask

  task automatic model_reset();
    mq.delete();
    m_ack   = 1'b0;
    m_drops = 0;
  endtask

  initial begin
    brlite_flit_t f;
    n_cmp = 0;
    n_mis = 0;
    rst_ni = 1'b0;
    br_req_i = 1'b0;
    br_svc_ack_i = 1'b0;
    br_data_i = '0;
    rt_seen = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_all();
    rst_ni = 1'b1;
    step();

    // single flit, then NI pop
    f = mk_flit(2'd1, 8'h2A, 16'h0102, 16'h0003, 32'hDEADBEEF);
    send(f, 10);
    check_eq("single_payload", 72'(br_svc_data_o.payload), 72'(32'hDEADBEEF));
    check_eq("single_ksvc", 72'(br_svc_data_o.ksvc), 72'(8'h2A));
    pop();
    check_eq("single_popped_rx", 72'(br_svc_rx_o), 72'(0));

    // filtered flit
    send(mk_flit(2'd0, 8'h00, 16'h0000, 16'h0000, 32'h55), 10);
    check_eq("filter_drop", 72'(drop_cnt_o), 72'(1));
    check_eq("filter_cnt", 72'(svc_count_o), 72'(0));

    // fill to capacity, ninth flit stalls until a slot frees
    for (int i = 0; i < DEPTH; i++) send(mk_flit(2'd1, 8'h10, 16'h0001, 16'(i), 32'(i)), 10);
    offer(mk_flit(2'd1, 8'h10, 16'h0001, 16'd8, 32'd8));
    repeat (6) step();
    check_eq("full_count", 72'(svc_count_o), 72'(8));
    check_eq("full_stall_req", 72'(br_req_i), 72'(1));
    check_eq("full_head", 72'(br_svc_data_o.payload), 72'(0));
    pop();
    for (int i = 0; i < 3 && !rt_seen; i++) step();
    check_eq("ninth_acked", 72'(rt_seen), 72'(1));
    for (int i = 0; i < 4 && br_req_i; i++) step();
    for (int i = 1; i <= DEPTH; i++) begin
      check_eq("fill_order", 72'(br_svc_data_o.payload), 72'(i));
      pop();
    end

    // simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++) send(mk_flit(2'd1, 8'h33, 16'h0002, 16'(i), 32'h100 + 32'(i)), 10);
    offer(mk_flit(2'd1, 8'h33, 16'h0002, 16'h0009, 32'h200));
    br_svc_ack_i = 1'b1;
    step();
    for (int i = 0; i < 4 && br_req_i; i++) step();
    check_eq("simul_count", 72'(svc_count_o), 72'(3));
    check_eq("simul_head", 72'(br_svc_data_o.payload), 72'(32'h101));
    repeat (3) pop();

    // pop while empty must not disturb pointers
    pop();
    send(mk_flit(2'd1, 8'h44, 16'h0003, 16'h0004, 32'h77), 10);
    check_eq("empty_pop_head", 72'(br_svc_data_o.payload), 72'(32'h77));
    pop();

    // drop counter saturation
    force dut.drop_cnt_r = 16'hFFFF;
    #1;
    release dut.drop_cnt_r;
    m_drops = DROP_MAX;
    send(rnd_flit(2'd3), 10);
    check_eq("drop_sat", 72'(drop_cnt_o), 72'(16'hFFFF));

    // reset during the ACK cycle with two entries buffered
    send(rnd_flit(2'd1), 10);
    send(rnd_flit(2'd1), 10);
    offer(rnd_flit(2'd2));
    for (int i = 0; i < 4 && !br_ack_o; i++) step();
    check_eq("pre_reset_count", 72'(svc_count_o), 72'(2));
    #1 rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    rt_seen = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6 && br_req_i; i++) step();
    check_eq("reaccept_drop", 72'(drop_cnt_o), 72'(1));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (!br_req_i && ($urandom_range(0, 2) != 0))
        offer(rnd_flit(($urandom_range(0, 3) != 0) ? 2'd1 : 2'($urandom_range(0, 3))));
      br_svc_ack_i = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
